// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared constants for the multi-cycle MIPS control unit:
//               opcode/funct values, ALU op codes, FSM state encodings,
//               datapath select codes and the decoded instruction class.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Register written by jal (the datapath maps reg_dst code 2 onto it)
    localparam logic [4:0] RA_REG = 5'd31;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    // R-type funct codes
    localparam logic [5:0] c_FN_ADDU  = 6'b100001;
    localparam logic [5:0] c_FN_SUBU  = 6'b100011;
    localparam logic [5:0] c_FN_JR    = 6'b001000;

    // ALU operation codes (shared with the ALU)
    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_SUB  = 3'd1;
    localparam logic [2:0] c_ALU_OR   = 3'd2;
    localparam logic [2:0] c_ALU_LUI  = 3'd3;

    // FSM state encodings
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_DECODE = 3'd1;
    localparam logic [2:0] c_ST_EXE    = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;

    // PC source select
    localparam logic [1:0] c_PC_PLUS4  = 2'd0;
    localparam logic [1:0] c_PC_BRANCH = 2'd1;
    localparam logic [1:0] c_PC_JUMP   = 2'd2;
    localparam logic [1:0] c_PC_REG    = 2'd3;

    // Destination register select
    localparam logic [1:0] c_RD_RT     = 2'd0;
    localparam logic [1:0] c_RD_RD     = 2'd1;
    localparam logic [1:0] c_RD_RA     = 2'd2;

    // Write-data select
    localparam logic [1:0] c_WD_ALU    = 2'd0;
    localparam logic [1:0] c_WD_MEM    = 2'd1;
    localparam logic [1:0] c_WD_PC4    = 2'd2;

    // One-hot instruction class; all-zero means "execute as nop"
    typedef struct packed {
        logic addu;
        logic subu;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
    } instr_class_t;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_decode
// Description : Purely combinational instruction decoder. Maps the IR word
//               onto a one-hot instruction class; unsupported encodings
//               (including sll $0 nop) decode to an all-zero class.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_unused_fields;

    assign w_opcode        = instr[31:26];
    assign w_funct         = instr[5:0];
    // Register/immediate fields are consumed by the datapath, not here
    assign w_unused_fields = ^instr[25:6];

    // Classify the instruction from opcode and, for R-type, funct
    always_comb begin
        cls      = '0;
        cls.addu = (w_opcode == c_OP_RTYPE) && (w_funct == c_FN_ADDU);
        cls.subu = (w_opcode == c_OP_RTYPE) && (w_funct == c_FN_SUBU);
        cls.jr   = (w_opcode == c_OP_RTYPE) && (w_funct == c_FN_JR);
        cls.ori  = (w_opcode == c_OP_ORI);
        cls.lui  = (w_opcode == c_OP_LUI);
        cls.lw   = (w_opcode == c_OP_LW);
        cls.sw   = (w_opcode == c_OP_SW);
        cls.beq  = (w_opcode == c_OP_BEQ);
        cls.j    = (w_opcode == c_OP_J);
        cls.jal  = (w_opcode == c_OP_JAL);
    end

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl
// Description : Multi-cycle MIPS control unit. Sequences FETCH / DECODE /
//               EXE / MEM / WB and drives every datapath enable and select
//               combinationally from the state register and the IR.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        alu_equal,
    output logic [2:0]  state,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src_b,
    output logic        ext_op,
    output logic [2:0]  alu_op,
    output logic        mem_write,
    output logic        retire
);

    logic [2:0]   r_state;
    logic [2:0]   w_next_state;
    instr_class_t w_cls;
    logic         w_rtype_alu;
    logic         w_imm_alu;

    // Raw (unmasked) control values
    logic         w_pc_write;
    logic [1:0]   w_pc_src;
    logic         w_ir_write;
    logic         w_reg_write;
    logic [1:0]   w_reg_dst;
    logic [1:0]   w_wd_sel;
    logic         w_alu_src_b;
    logic         w_ext_op;
    logic [2:0]   w_alu_op;
    logic         w_mem_write;
    logic         w_retire;

    mc_decode u_decode (
        .instr (instr),
        .cls   (w_cls)
    );

    assign w_rtype_alu = w_cls.addu | w_cls.subu;
    assign w_imm_alu   = w_cls.ori  | w_cls.lui;

    // State register: the only flop; reset returns to FETCH immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; illegal encodings fall back to FETCH
    always_comb begin
        w_next_state = c_ST_FETCH;
        case (r_state)
            c_ST_FETCH: begin
                w_next_state = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                if (w_rtype_alu || w_imm_alu || w_cls.lw || w_cls.sw || w_cls.beq)
                    w_next_state = c_ST_EXE;
                else
                    w_next_state = c_ST_FETCH;
            end
            c_ST_EXE: begin
                if (w_cls.lw || w_cls.sw)
                    w_next_state = c_ST_MEM;
                else if (w_rtype_alu || w_imm_alu)
                    w_next_state = c_ST_WB;
                else
                    w_next_state = c_ST_FETCH;
            end
            c_ST_MEM: begin
                if (w_cls.lw)
                    w_next_state = c_ST_WB;
                else
                    w_next_state = c_ST_FETCH;
            end
            default: begin
                w_next_state = c_ST_FETCH;
            end
        endcase
    end

    // Output decode from state and instruction class
    always_comb begin
        w_pc_write  = 1'b0;
        w_pc_src    = c_PC_PLUS4;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_reg_dst   = c_RD_RT;
        w_wd_sel    = c_WD_ALU;
        w_alu_src_b = 1'b0;
        w_ext_op    = 1'b0;
        w_alu_op    = c_ALU_ADD;
        w_mem_write = 1'b0;
        w_retire    = 1'b0;

        // ALU control is set in EXE and held through MEM/WB so the address
        // and result stay stable until the instruction retires
        if ((r_state == c_ST_EXE) || (r_state == c_ST_MEM) || (r_state == c_ST_WB)) begin
            if (w_cls.subu) begin
                w_alu_op = c_ALU_SUB;
            end else if (w_cls.ori) begin
                w_alu_op    = c_ALU_OR;
                w_alu_src_b = 1'b1;
            end else if (w_cls.lui) begin
                w_alu_op    = c_ALU_LUI;
                w_alu_src_b = 1'b1;
            end else if (w_cls.lw || w_cls.sw) begin
                w_alu_src_b = 1'b1;
                w_ext_op    = 1'b1;
            end else if (w_cls.beq) begin
                w_alu_op = c_ALU_SUB;
                w_ext_op = 1'b1;
            end
        end

        case (r_state)
            c_ST_FETCH: begin
                w_ir_write = 1'b1;
                w_pc_write = 1'b1;
            end
            c_ST_DECODE: begin
                if (w_cls.j || w_cls.jal) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = c_PC_JUMP;
                    w_retire   = 1'b1;
                    if (w_cls.jal) begin
                        // PC already holds PC+4 from FETCH: link that value
                        w_reg_write = 1'b1;
                        w_reg_dst   = c_RD_RA;
                        w_wd_sel    = c_WD_PC4;
                    end
                end else if (w_cls.jr) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = c_PC_REG;
                    w_retire   = 1'b1;
                end else if (!(w_rtype_alu || w_imm_alu || w_cls.lw || w_cls.sw || w_cls.beq)) begin
                    w_retire = 1'b1;
                end
            end
            c_ST_EXE: begin
                if (w_cls.beq) begin
                    w_pc_src   = c_PC_BRANCH;
                    w_pc_write = alu_equal;
                    w_retire   = 1'b1;
                end
            end
            c_ST_MEM: begin
                if (w_cls.sw) begin
                    w_mem_write = 1'b1;
                    w_retire    = 1'b1;
                end
            end
            c_ST_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                if (w_rtype_alu) begin
                    w_reg_dst = c_RD_RD;
                end else if (w_cls.lw) begin
                    w_wd_sel = c_WD_MEM;
                end
            end
            default: begin
            end
        endcase
    end

    // Reset masks enables and selects combinationally so a pending write is
    // abandoned in the same cycle reset asserts
    assign state     = r_state;
    assign pc_write  = reset & w_pc_write;
    assign ir_write  = reset & w_ir_write;
    assign reg_write = reset & w_reg_write;
    assign mem_write = reset & w_mem_write;
    assign retire    = reset & w_retire;
    assign pc_src    = reset ? w_pc_src    : 2'd0;
    assign reg_dst   = reset ? w_reg_dst   : 2'd0;
    assign wd_sel    = reset ? w_wd_sel    : 2'd0;
    assign alu_src_b = reset & w_alu_src_b;
    assign ext_op    = reset & w_ext_op;
    assign alu_op    = reset ? w_alu_op    : 3'd0;

endmodule : mc_ctrl
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit that drives the ALU op/operand-select interface and consumes its `equal` flag.
- Decodes the instruction held in the external IR.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
- Emits every datapath write enable and mux select for the multi-cycle CPU.

Parameters:
- RA_REG, 5'd31, register written by jal.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- instr  in  32  current IR contents
- alu_equal  in  1  ALU operand1==operand2 flag
- state  out  3  current FSM state (debug/verification)
- pc_write  out  1  PC register load enable
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target {PC[31:28],imm26,2'b00}, 3 rs value
- ir_write  out  1  IR load enable
- reg_write  out  1  GRF write enable
- reg_dst  out  2  0 rt, 1 rd, 2 RA_REG
- wd_sel  out  2  0 ALU result, 1 memory data, 2 PC+4
- alu_src_b  out  1  0 rt value, 1 extended imm16
- ext_op  out  1  0 zero-extend, 1 sign-extend
- alu_op  out  3  0 ADD, 1 SUB, 2 OR, 3 LUI
- mem_write  out  1  DM write enable
- retire  out  1  one-cycle pulse on the last cycle of each instruction

Behaviour:
- Supported instructions (opcode/funct):
  - addu 000000/100001
  - subu 000000/100011
  - jr 000000/001000
  - ori 001101
  - lui 001111
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - jal 000011
  - Anything else, including sll $0 (nop), executes as nop.
- States: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. The state register is the only flop.
- reset low: state=FETCH immediately (async). All enables (pc_write, ir_write, reg_write, mem_write, retire) are forced 0 while reset is low. Selects are 0.
- First FETCH after reset release behaves normally.
- FETCH: ir_write=1, pc_write=1, pc_src=0. Next state is DECODE.
- DECODE:
  - j: pc_write=1, pc_src=2, retire=1. Next FETCH.
  - jal: as j, plus reg_write=1, reg_dst=2, wd_sel=2 (PC+4 is the already-incremented PC). Next FETCH.
  - jr: pc_write=1, pc_src=3, retire=1. Next FETCH.
  - Unknown/nop: retire=1. Next FETCH.
  - All others: next EXE.
- EXE:
  - addu: alu_op=ADD, alu_src_b=0.
  - subu: alu_op=SUB, alu_src_b=0.
  - ori: alu_op=OR, alu_src_b=1, ext_op=0.
  - lui: alu_op=LUI, alu_src_b=1.
  - lw/sw: alu_op=ADD, alu_src_b=1, ext_op=1.
  - beq: alu_op=SUB, alu_src_b=0, ext_op=1, pc_src=1, pc_write=alu_equal, retire=1. Next FETCH.
  - lw/sw next MEM. R-type/ori/lui next WB.
- MEM:
  - sw: mem_write=1, retire=1. Next FETCH.
  - lw: no writes. Next WB.
  - ALU control is held at its EXE values through MEM and WB, so the address and result stay stable.
- WB: reg_write=1, retire=1. Next FETCH.
  - R-type: reg_dst=1, wd_sel=0.
  - ori/lui: reg_dst=0, wd_sel=0.
  - lw: reg_dst=0, wd_sel=1.
- All outputs are combinational from state and instr. The IR changes only on the FETCH edge, so decode is stable for the whole instruction.
- Latency in cycles: j/jal/jr/nop 2; beq 3; R-type/ori/lui/sw 4; lw 5.
- retire is high in exactly one cycle per instruction.
- Illegal state encodings (5–7) return to FETCH next cycle with all enables 0.
- Reset asserted mid-instruction: any pending MEM/WB write is abandoned. Enables drop in the same cycle (async).
- Writes to register $0 are not filtered here; the GRF handles them.

Decomposition:
- Shared package/header holds:
  - opcode and funct constants;
  - ALU op codes ADD=0, SUB=1, OR=2, LUI=3 (must match the ALU);
  - state encodings;
  - pc_src, reg_dst and wd_sel codes.
- Optional sub-module mc_decode: purely combinational `instr` → one-hot instruction class. The FSM stays in mc_ctrl.

Test Plan:
- Hold reset low for 3 cycles mid-DECODE, then release → state=0 within the same cycle as assertion. All enables 0 during reset. First post-release cycle has ir_write=1, pc_write=1.
- addu $3,$1,$2 (0x00221821) → states 0,1,2,4. In EXE alu_op=0, alu_src_b=0. In WB reg_write=1, reg_dst=1, retire=1.
- lw $4,8($5) (0x8CA40008) → states 0,1,2,3,4. ext_op=1, alu_op=0. In WB wd_sel=1, reg_write=1. mem_write never set.
- beq with alu_equal=1, then repeated with alu_equal=0 → 3 cycles each. EXE pc_src=1, alu_op=1, pc_write=1 and 0 respectively.
- jal 0x0C000010 → 2 cycles. DECODE has pc_write=1, pc_src=2, reg_write=1, reg_dst=2, wd_sel=2.
- Unknown opcode 0xFC000000, then lui $1,0x1234 → nop retires in 2 cycles with no writes. lui runs 4 cycles with alu_op=3, reg_dst=0. Exactly one retire per instruction.
